decode_stage: RTL and testbench

- Instruction-decode stage directly downstream of the fetch stage.
- Consumes the 67-bit fetch bundle and buffers it in a 2-entry skid FIFO.
- Splits the 32-bit instruction into register, immediate and control fields, then presents a registered decoded bundle to execute under valid/ready.
- Back-pressures fetch through fetch_ready, which fetch uses as its PC enable.

---
 rtl/decode_pkg.sv | 49 ++++
 rtl/decode_fields.sv | 46 ++++
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared opcode map, class encodings, fetch-bundle layout and decoded-bundle
// type for the instruction-decode stage.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] CLS_R   = 2'd0;
    localparam logic [1:0] CLS_I   = 2'd1;
    localparam logic [1:0] CLS_J   = 2'd2;
    localparam logic [1:0] CLS_BAD = 2'd3;

    localparam int FB_W        = 67;
    localparam int FB_VALID    = 66;
    localparam int FB_PC_HI    = 65;
    localparam int FB_PC_LO    = 61;
    localparam int FB_INSTR_HI = 60;
    localparam int FB_INSTR_LO = 29;
    localparam int FB_RSVD_HI  = 28;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [1:0]  cls;
        logic        illegal;
    } dec_bundle_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction splitter: classifies the opcode and builds the
// extended immediate for one 32-bit instruction.
module decode_fields
    import decode_pkg::*;
(
    input  logic [31:0]  instr,
    output dec_bundle_t  fields
);

    // Field extraction with opcode-dependent class, rd masking and immediate
    always_comb begin
        fields         = '0;
        fields.opcode  = instr[31:26];
        fields.rs      = instr[25:21];
        fields.rt      = instr[20:16];
        fields.shamt   = instr[10:6];
        fields.funct   = instr[5:0];
        case (instr[31:26])
            OP_RTYPE: begin
                fields.cls = CLS_R;
                fields.rd  = instr[15:11];
            end
            OP_J, OP_JAL: begin
                fields.cls = CLS_J;
                fields.imm = {6'h00, instr[25:0]};
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                fields.cls = CLS_I;
                fields.imm = {16'h0000, instr[15:0]};
            end
            OP_LUI: begin
                fields.cls = CLS_I;
                fields.imm = {instr[15:0], 16'h0000};
            end
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW, OP_SW: begin
                fields.cls = CLS_I;
                fields.imm = sext16(instr[15:0]);
            end
            default: begin
                fields.cls     = CLS_BAD;
                fields.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetch bundles at push time into a small skid FIFO and
// presents the head entry to execute from registers under valid/ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FB_W-1:0]   fetch_in,
    output logic              fetch_ready,
    input  logic              flush,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [4:0]        dec_pc,
    output logic [5:0]        dec_opcode,
    output logic [4:0]        dec_rs,
    output logic [4:0]        dec_rt,
    output logic [4:0]        dec_rd,
    output logic [4:0]        dec_shamt,
    output logic [5:0]        dec_funct,
    output logic [31:0]       dec_imm,
    output logic [1:0]        dec_class,
    output logic              dec_illegal,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    dec_bundle_t        decoded_s;
    dec_bundle_t        mem_r [DEPTH];
    logic [4:0]         mem_pc_r [DEPTH];
    dec_bundle_t        head_r, head_n_s;
    logic [4:0]         head_pc_r, head_pc_n_s;
    logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r, rd_ptr_n_s, wr_ptr_n_s;
    logic [CW-1:0]      count_r, count_n_s;
    logic               valid_r, ready_r;
    logic [CNT_W-1:0]   instr_count_r;
    logic               push_s, pop_s;
    logic               unused_rsvd_s;

    // Reserved bundle bits are deliberately never looked at
    assign unused_rsvd_s = ^fetch_in[FB_RSVD_HI:0];

    decode_fields u_fields (
        .instr  (fetch_in[FB_INSTR_HI:FB_INSTR_LO]),
        .fields (decoded_s)
    );

    assign push_s = fetch_in[FB_VALID] & ready_r & ~flush;
    assign pop_s  = valid_r & dec_ready & ~flush;

    // Next pointers/count and the entry that becomes head after this edge
    always_comb begin
        rd_ptr_n_s  = rd_ptr_r;
        wr_ptr_n_s  = wr_ptr_r;
        count_n_s   = count_r;
        head_n_s    = head_r;
        head_pc_n_s = head_pc_r;
        if (flush) begin
            rd_ptr_n_s = '0;
            wr_ptr_n_s = '0;
            count_n_s  = '0;
        end else begin
            rd_ptr_n_s = rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_n_s = wr_ptr_r + PTR_W'(push_s);
            count_n_s  = count_r + CW'(push_s) - CW'(pop_s);
        end
        // A bundle written into the slot that becomes head bypasses storage
        if (count_n_s == '0) begin
            head_n_s    = head_r;
            head_pc_n_s = head_pc_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_n_s)) begin
            head_n_s    = decoded_s;
            head_pc_n_s = fetch_in[FB_PC_HI:FB_PC_LO];
        end else begin
            head_n_s    = mem_r[rd_ptr_n_s];
            head_pc_n_s = mem_pc_r[rd_ptr_n_s];
        end
    end

    // Control state, registered head view and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            valid_r       <= 1'b0;
            ready_r       <= 1'b1;
            head_r        <= '0;
            head_pc_r     <= 5'd0;
            instr_count_r <= '0;
        end else begin
            rd_ptr_r  <= rd_ptr_n_s;
            wr_ptr_r  <= wr_ptr_n_s;
            count_r   <= count_n_s;
            valid_r   <= (count_n_s != '0);
            ready_r   <= (count_n_s < FULL_CNT);
            head_r    <= head_n_s;
            head_pc_r <= head_pc_n_s;
            if (pop_s && (instr_count_r != {CNT_W{1'b1}})) begin
                instr_count_r <= instr_count_r + CNT_W'(1);
            end else begin
                instr_count_r <= instr_count_r;
            end
        end
    end

    // FIFO storage; flush only rewinds pointers, contents are kept
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i]    <= '0;
                mem_pc_r[i] <= 5'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r]    <= decoded_s;
            mem_pc_r[wr_ptr_r] <= fetch_in[FB_PC_HI:FB_PC_LO];
        end else begin
            mem_r[wr_ptr_r]    <= mem_r[wr_ptr_r];
            mem_pc_r[wr_ptr_r] <= mem_pc_r[wr_ptr_r];
        end
    end

    assign fetch_ready = ready_r;
    assign dec_valid   = valid_r;
    assign dec_pc      = head_pc_r;
    assign dec_opcode  = head_r.opcode;
    assign dec_rs      = head_r.rs;
    assign dec_rt      = head_r.rt;
    assign dec_rd      = head_r.rd;
    assign dec_shamt   = head_r.shamt;
    assign dec_funct   = head_r.funct;
    assign dec_imm     = head_r.imm;
    assign dec_class   = head_r.cls;
    assign dec_illegal = head_r.illegal;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed plan steps then random traffic, all checked
// every cycle against a queue-based reference of the stage behaviour.
module tb_decode_stage;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [1:0]  cls;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] ins;
    } fb_t;

    logic        clk = 1'b0;
    logic        rst, flush, dec_ready;
    logic [66:0] fetch_in;
    logic        fetch_ready, dec_valid, dec_illegal;
    logic [4:0]  dec_pc, dec_rs, dec_rt, dec_rd, dec_shamt;
    logic [5:0]  dec_opcode, dec_funct;
    logic [31:0] dec_imm;
    logic [1:0]  dec_class;
    logic [15:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    fb_t         q[$];
    exp_t        e;
    logic [4:0]  e_pc;
    logic [15:0] m_cnt;
    bit          m_acc;

    decode_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fetch_in(fetch_in), .fetch_ready(fetch_ready),
        .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_opcode(dec_opcode), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rd(dec_rd), .dec_shamt(dec_shamt), .dec_funct(dec_funct),
        .dec_imm(dec_imm), .dec_class(dec_class), .dec_illegal(dec_illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t r;
        int   op;
        op      = int'(ins[31:26]);
        r       = '0;
        r.op    = ins[31:26];
        r.rs    = ins[25:21];
        r.rt    = ins[20:16];
        r.shamt = ins[10:6];
        r.funct = ins[5:0];
        if (op == 0) begin
            r.cls = 2'd0;
            r.rd  = ins[15:11];
        end else if (op == 2 || op == 3) begin
            r.cls = 2'd2;
            r.imm = ins & 32'h03FF_FFFF;
        end else if (op inside {12, 13, 14}) begin
            r.cls = 2'd1;
            r.imm = ins & 32'h0000_FFFF;
        end else if (op == 15) begin
            r.cls = 2'd1;
            r.imm = ins << 16;
        end else if (op inside {4, 5, 8, 9, 10, 35, 43}) begin
            r.cls = 2'd1;
            r.imm = 32'(int'($signed(ins[15:0])));
        end else begin
            r.cls = 2'd3;
            r.ill = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [4:0] pc,
                              input logic [31:0] ins, input logic fl, input logic rdy);
        bit push, pop;
        if (r) begin
            q.delete();
            e     = '0;
            e_pc  = 5'd0;
            m_cnt = 16'd0;
            m_acc = 1'b0;
        end else begin
            push  = v && (q.size() < 2) && !fl;
            pop   = (q.size() > 0) && rdy && !fl;
            m_acc = push;
            if (fl) begin
                q.delete();
            end else begin
                if (pop) begin
                    q.delete(0);
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
                if (push) q.push_back(fb_t'{pc, ins});
            end
            if (q.size() > 0) begin
                e_pc = q[0].pc;
                e    = ref_decode(q[0].ins);
            end
        end
    endtask

    task automatic compare_all();
        check("dec_valid", 128'(dec_valid), 128'(q.size() > 0));
        check("fetch_ready", 128'(fetch_ready), 128'(q.size() < 2));
        check("instr_count", 128'(instr_count), 128'(m_cnt));
        check("fields", 128'({dec_pc, dec_opcode, dec_rs, dec_rt, dec_rd, dec_shamt,
                              dec_funct, dec_imm, dec_class, dec_illegal}),
              128'({e_pc, e}));
    endtask

    task automatic step(input logic r, input logic v, input logic [4:0] pc,
                        input logic [31:0] ins, input logic fl, input logic rdy);
        rst       = r;
        fetch_in  = {v, pc, ins, {29{1'bx}}};
        flush     = fl;
        dec_ready = rdy;
        @(posedge clk);
        model_edge(r, v, pc, ins, fl, rdy);
        #1;
        compare_all();
    endtask

    logic [4:0]  popped[$];
    logic [15:0] base;
    bit          pending;
    int          legal_ops[14] = '{0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 15, 35, 43};

    initial begin
        rst = 1'b1; flush = 1'b0; dec_ready = 1'b0; fetch_in = '0;
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd9, 32'h2008FFFC, 1'b1, 1'b1);
        check("reset_zero", 128'({dec_valid, instr_count, dec_pc, dec_opcode, dec_rs, dec_rt,
                                  dec_rd, dec_shamt, dec_funct, dec_imm, dec_class, dec_illegal}), 128'd0);
        check("reset_ready", 128'(fetch_ready), 128'd1);

        // ADDI with negative immediate, then pop it
        step(1'b0, 1'b1, 5'd5, 32'h2008FFFC, 1'b0, 1'b1);
        check("addi_imm", 128'(dec_imm), 128'h0000_0000_FFFF_FFFC);
        check("addi_cls_rt_pc", 128'({dec_valid, dec_class, dec_rt, dec_pc}), 128'({1'b1, 2'd1, 5'd8, 5'd5}));
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        check("addi_count", 128'(instr_count), 128'd1);

        step(1'b0, 1'b1, 5'd1, 32'h3409FFFF, 1'b0, 1'b1);
        check("ori_imm", 128'(dec_imm), 128'h0000_FFFF);
        step(1'b0, 1'b1, 5'd2, 32'h3C0A1234, 1'b0, 1'b1);
        check("lui_imm", 128'(dec_imm), 128'h1234_0000);
        step(1'b0, 1'b1, 5'd3, 32'h012A5820, 1'b0, 1'b1);
        check("rtype", 128'({dec_class, dec_rd, dec_funct, dec_imm}), 128'({2'd0, 5'd11, 6'h20, 32'h0}));
        step(1'b0, 1'b1, 5'd4, 32'hFC000000, 1'b0, 1'b1);
        check("illegal", 128'({dec_illegal, dec_class}), 128'({1'b1, 2'd3}));
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Fill with execute stalled; third bundle must be held by fetch
        step(1'b0, 1'b1, 5'd0, 32'h2001_0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd1, 32'h2002_0001, 1'b0, 1'b0);
        check("full_ready", 128'(fetch_ready), 128'd0);
        step(1'b0, 1'b1, 5'd2, 32'h2003_0002, 1'b0, 1'b0);
        check("full_head", 128'(dec_pc), 128'd0);
        pending = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (dec_valid) popped.push_back(dec_pc);
            step(1'b0, pending, 5'd2, 32'h2003_0002, 1'b0, 1'b1);
            if (m_acc) pending = 1'b0;
        end
        check("order_n", 128'(popped.size()), 128'd3);
        for (int i = 0; i < popped.size(); i++) check("order_pc", 128'(popped[i]), 128'(i));

        // Streaming at count=1
        step(1'b0, 1'b1, 5'd7, 32'h8C00_0010, 1'b0, 1'b1);
        base = m_cnt;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 5'(i + 8), 32'hAC00_0000 | 32'(i), 1'b0, 1'b1);
            check("stream_ready", 128'({fetch_ready, dec_valid}), 128'b11);
        end
        check("stream_count", 128'(instr_count), 128'(base + 16'd10));
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Flush with two buffered and a concurrent valid bundle
        step(1'b0, 1'b1, 5'd3, 32'h3000_0003, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd4, 32'h3000_0004, 1'b0, 1'b0);
        base = m_cnt;
        step(1'b0, 1'b1, 5'd5, 32'h3000_0005, 1'b1, 1'b1);
        check("flush_state", 128'({dec_valid, fetch_ready}), 128'b01);
        check("flush_count", 128'(instr_count), 128'(base));

        // Reset during a pop
        step(1'b0, 1'b1, 5'd6, 32'h2000_0006, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd7, 32'h2000_0007, 1'b0, 1'b1);
        check("rst_pop", 128'({dec_valid, instr_count, dec_pc, dec_opcode, dec_rs, dec_rt,
                               dec_rd, dec_shamt, dec_funct, dec_imm, dec_class, dec_illegal}), 128'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(legal_ops[$urandom_range(0, 13)]);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 5'($urandom),
                 {op, 26'($urandom)}, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
